gate_bist_driver: RTL and testbench
===================================

Name: gate_bist_driver

Overview:
- Sequential stimulus/response engine for the combinational gate models in the simulator gate library: 24-bit primary-input vector in, 10-bit primary-output vector back.
- Generates pseudo-random input vectors with an LFSR and drives them onto a gate model.
- Waits a settle interval, then compacts the model's outputs into a MISR signature and compares it with a golden value.
- Sits between the lab test sequencer and any gate model instance.

Parameters:
- IN_W, 24, width of dut_in (gate-model primary inputs).
- OUT_W, 10, width of dut_out (gate-model primary outputs).
- PAT_CNT, 256, patterns per run; range 1..65535.
- SETTLE, 2, cycles each pattern is held before capture; range 1..15.
- LFSR_SEED, 24'h000001, LFSR start value; must be nonzero (elaboration error if 0).
- MISR_SEED, 10'h000, MISR start value.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- abort  in  1  ends the run; returns to IDLE without asserting done.
- golden  in  OUT_W  expected signature; sampled in the cycle done rises.
- dut_out  in  OUT_W  gate-model outputs.
- dut_in  out  IN_W  gate-model inputs (registered).
- busy  out  1  high in APPLY and CAPTURE.
- done  out  1  high in DONE.
- pass  out  1  valid while done; signature == golden.
- signature  out  OUT_W  MISR contents (registered).
- pat_idx  out  16  number of patterns captured so far.

Behaviour:
- Reset (async assert, sync release): state = IDLE, dut_in = 0, signature = 0, pat_idx = 0, busy = done = pass = 0.
- LFSR: Fibonacci, left shift. new bit = l[23] ^ l[22] ^ l[21] ^ l[16]; l_next = {l[22:0], new}.
- MISR: m_next = {m[8:0], m[9] ^ m[6]} ^ dut_out.
- IDLE, start = 1:
  - dut_in <= LFSR_SEED, signature <= MISR_SEED, pat_idx <= 0, settle counter <= SETTLE-1.
  - Go to APPLY.
- APPLY: dut_in held stable. Counter decrements each cycle; at 0, go to CAPTURE. APPLY lasts exactly SETTLE cycles.
- CAPTURE (1 cycle):
  - signature <= m_next using the current dut_out.
  - pat_idx <= pat_idx + 1.
  - If pat_idx + 1 == PAT_CNT, go to DONE and leave dut_in unchanged.
  - Otherwise dut_in <= l_next, reload the counter, go to APPLY.
- Run length: PAT_CNT*(SETTLE+1) cycles from the start-accept edge to the done-rise edge.
- DONE:
  - done = 1; pass registered on entry as (MISR result == golden).
  - Stays in DONE until start (acts like the IDLE start, including re-seeding; done drops next cycle) or abort (go to IDLE).
- start while busy: ignored.
- abort in any state: next state IDLE. dut_in, signature and pat_idx keep their values; done = pass = 0.
- abort and start in the same cycle: abort wins.
- Reset mid-run: immediate return to reset values; no partial result is reported.
- pat_idx arithmetic: 16-bit, never wraps because PAT_CNT ≤ 65535.
- dut_out is only sampled in CAPTURE; glitches during APPLY have no effect.

Decomposition:
- Shared package gate_bist_pkg:
  - state enum {IDLE, APPLY, CAPTURE, DONE};
  - LFSR tap constant 24'hE10000;
  - MISR tap constant 10'h240;
  - default seeds.
- One natural sub-module, gate_bist_lfsr: parameterized width/taps/seed, with load and step inputs. Instantiated for the LFSR.
- The MISR is inline: it is a single expression with a dut_out XOR.

Test Plan:
- Reset: assert rst mid-APPLY -> dut_in = 0, signature = 0, pat_idx = 0, busy = 0 within the same cycle (async).
- PAT_CNT = 2, SETTLE = 2, seed 24'h000001:
  - start -> dut_in = 000001 for 2 APPLY cycles, then 000002;
  - done rises exactly 6 cycles after start accept.
- MISR, MISR_SEED = 0, dut_out tied to 10'h001, PAT_CNT = 2 -> signature 001 after the first capture, 003 after the second.
- golden = 10'h003 for the previous run -> pass = 1; golden = 10'h002 -> pass = 0.
- start pulses during busy are ignored (done timing unchanged); start in DONE restarts with dut_in = 000001 and pat_idx = 0.
- abort in the same cycle as start while in DONE -> IDLE, done = 0, no restart. abort mid-run -> IDLE with pat_idx frozen at its value.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST driver.
// The LFSR/MISR tap masks mark the bit positions that feed each feedback XOR.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } bist_state_e;

  localparam int          CNT_W          = 4;
  localparam logic [23:0] LFSR_TAPS      = 24'hE10000;
  localparam logic [9:0]  MISR_TAPS      = 10'h240;
  localparam logic [23:0] LFSR_SEED_DFLT = 24'h000001;
  localparam logic [9:0]  MISR_SEED_DFLT = 10'h000;

endpackage

// File: rtl/gate_bist_lfsr.sv
// Fibonacci left-shift LFSR: the new LSB is the XOR of the bits selected by TAPS.
// Cleared to zero by reset; load the seed before stepping.
module gate_bist_lfsr #(
  parameter int             W    = 24,
  parameter logic [W-1:0]   TAPS = '1,
  parameter logic [W-1:0]   SEED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= SEED;
    else if (step)
      q <= {q[W-2:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/gate_bist_driver.sv
// Gate-model BIST driver: applies LFSR patterns, holds each for SETTLE cycles,
// compacts dut_out into a MISR and compares the final signature with golden.
//
// state   | meaning
// IDLE    | waiting for start; outputs keep last run's values
// APPLY   | pattern on dut_in, settle counter running down
// CAPTURE | one cycle: fold dut_out into MISR, advance pattern or finish
// DONE    | run complete, pass valid, waiting for start or abort
module gate_bist_driver
  import gate_bist_pkg::*;
#(
  parameter int               IN_W      = 24,
  parameter int               OUT_W     = 10,
  parameter int               PAT_CNT   = 256,
  parameter int               SETTLE    = 2,
  parameter logic [IN_W-1:0]  LFSR_SEED = LFSR_SEED_DFLT,
  parameter logic [OUT_W-1:0] MISR_SEED = MISR_SEED_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] golden,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      pat_idx
);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("gate_bist_driver: LFSR_SEED must be nonzero");
  end
  if (PAT_CNT < 1 || PAT_CNT > 65535 || SETTLE < 1 || SETTLE > 15) begin : g_bad_range
    $error("gate_bist_driver: PAT_CNT or SETTLE out of range");
  end

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [15:0]      PAT_LAST   = 16'(PAT_CNT - 1);

  bist_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             seed_load, lfsr_step, capture, cnt_load;
  logic             last_pat;
  logic [OUT_W-1:0] misr_nxt;

  assign last_pat = (pat_idx == PAT_LAST);
  assign misr_nxt = {signature[OUT_W-2:0], ^(signature & OUT_W'(MISR_TAPS))} ^ dut_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // abort overrides everything, including a start in the same cycle
  always_comb begin
    state_nxt = state;
    seed_load = 1'b0;
    lfsr_step = 1'b0;
    capture   = 1'b0;
    cnt_load  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            seed_load = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = APPLY;
          end
        end
        APPLY: begin
          if (cnt == '0)
            state_nxt = CAPTURE;
        end
        CAPTURE: begin
          capture = 1'b1;
          if (last_pat) begin
            state_nxt = DONE;
          end else begin
            lfsr_step = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = APPLY;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      signature <= '0;
      pat_idx   <= '0;
      pass      <= 1'b0;
    end else begin
      if (cnt_load)
        cnt <= CNT_RELOAD;
      else if (state == APPLY && cnt != '0)
        cnt <= cnt - CNT_W'(1);

      if (seed_load) begin
        signature <= MISR_SEED;
        pat_idx   <= '0;
      end else if (capture) begin
        signature <= misr_nxt;
        pat_idx   <= pat_idx + 16'd1;
      end

      // pass is only meaningful while sitting in DONE
      if (capture && last_pat)
        pass <= (misr_nxt == golden);
      else if (state_nxt != DONE)
        pass <= 1'b0;
    end
  end

  gate_bist_lfsr #(
    .W    (IN_W),
    .TAPS (IN_W'(LFSR_TAPS)),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .step (lfsr_step),
    .q    (dut_in)
  );

  assign busy = (state == APPLY) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gate_bist_driver.sv
// Bench for gate_bist_driver: a run-position model predicts every output each
// cycle, directed runs pin literal values, then randomized start/abort/dut_out.
module tb_gate_bist_driver;

  localparam int PAT_N = 24;
  localparam int SET_N = 2;
  localparam int RUN_CYC = PAT_N * (SET_N + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  golden = '0;
  logic [9:0]  dut_out = '0;
  logic [23:0] dut_in;
  logic        busy, done, pass;
  logic [9:0]  signature;
  logic [15:0] pat_idx;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  gate_bist_driver #(
    .IN_W(24), .OUT_W(10), .PAT_CNT(PAT_N), .SETTLE(SET_N),
    .LFSR_SEED(24'h000001), .MISR_SEED(10'h000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
    .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
    .pass(pass), .signature(signature), .pat_idx(pat_idx)
  );

  function automatic logic [23:0] lfsr_f(input logic [23:0] v);
    return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
  endfunction

  function automatic logic [9:0] misr_f(input logic [9:0] m, input logic [9:0] d);
    return {m[8:0], m[9] ^ m[6]} ^ d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 running, 2 done; position in run is an edge count.
  int          m_mode = 0;
  int          m_r    = 0;
  int          m_pidx = 0;
  logic [23:0] m_din  = '0;
  logic [9:0]  m_sig  = '0;
  bit          m_pass = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_r = 0; m_pidx = 0; m_din = '0; m_sig = '0; m_pass = 1'b0;
    end else if (abort) begin
      m_mode = 0; m_pass = 1'b0;
    end else if (m_mode != 1 && start) begin
      m_mode = 1; m_r = 0; m_pidx = 0; m_din = 24'h000001; m_sig = 10'h000; m_pass = 1'b0;
    end else if (m_mode == 1) begin
      m_r++;
      if (m_r % (SET_N + 1) == 0) begin
        m_sig = misr_f(m_sig, dut_out);
        m_pidx++;
        if (m_pidx == PAT_N) begin
          m_mode = 2;
          m_pass = (m_sig == golden);
        end else begin
          m_din = lfsr_f(m_din);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("dut_in",    32'(dut_in),    32'(m_din));
      chk("signature", 32'(signature), 32'(m_sig));
      chk("pat_idx",   32'(pat_idx),   32'(m_pidx));
      chk("busy",      32'(busy),      32'(m_mode == 1));
      chk("done",      32'(done),      32'(m_mode == 2));
      chk("pass",      32'(pass),      32'(m_pass));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int p;
    logic [9:0]  gf;
    logic [23:0] din_hold;
    bit s1, s2, s17, s18;

    gf = 10'h000;
    for (int i = 0; i < PAT_N; i++) gf = misr_f(gf, 10'h001);

    tick(); tick();
    armed = 1'b1;
    rst = 1'b0;
    tick();
    chk("rst_dut_in", 32'(dut_in), 32'h0);
    chk("rst_sig",    32'(signature), 32'h0);
    chk("rst_busy",   32'(busy), 32'h0);

    // Run 1: constant dut_out = 001, golden matches, a stray start mid-run
    dut_out = 10'h001;
    golden  = gf;
    start = 1'b1; tick(); start = 1'b0;
    chk("first_pattern", 32'(dut_in), 32'h000001);
    s1 = 0; s2 = 0; s17 = 0; s18 = 0;
    n = 0;
    while (!done && n < 1000) begin
      start = (n == 10);
      tick();
      start = 1'b0;
      n++;
      if (n == 2) chk("hold_pattern", 32'(dut_in), 32'h000001);
      if (pat_idx == 16'd1 && !s1) begin
        s1 = 1; chk("sig_cap1", 32'(signature), 32'h001); chk("second_pattern", 32'(dut_in), 32'h000002);
      end
      if (pat_idx == 16'd2 && !s2) begin
        s2 = 1; chk("sig_cap2", 32'(signature), 32'h003);
      end
      if (pat_idx == 16'd17 && !s17) begin
        s17 = 1; chk("pattern17", 32'(dut_in), 32'h020001);
      end
      if (pat_idx == 16'd18 && !s18) begin
        s18 = 1; chk("pattern18", 32'(dut_in), 32'h040002);
      end
    end
    chk("done_latency", 32'(n), 32'(RUN_CYC));
    chk("pass_match", 32'(pass), 32'h1);
    chk("final_sig", 32'(signature), 32'(gf));

    // Run 2: restart from DONE, golden off by one bit
    golden = gf ^ 10'h001;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done", 32'(done), 32'h0);
    chk("restart_din", 32'(dut_in), 32'h000001);
    chk("restart_idx", 32'(pat_idx), 32'h0);
    wait_done(n);
    chk("done_latency2", 32'(n), 32'(RUN_CYC));
    chk("pass_mismatch", 32'(pass), 32'h0);

    // abort together with start while in DONE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("abort_start_done", 32'(done), 32'h0);
    chk("abort_start_busy", 32'(busy), 32'h0);
    tick(); tick();
    chk("abort_start_idle", 32'(busy), 32'h0);

    // abort mid-run, on a capture edge
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    p = int'(pat_idx);
    chk("pre_abort_idx", 32'(p), 32'd6);
    din_hold = dut_in;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_idx", 32'(pat_idx), 32'd6);
    tick(); tick(); tick();
    chk("abort_idx_hold", 32'(pat_idx), 32'd6);
    chk("abort_din_hold", 32'(dut_in), 32'(din_hold));

    // async reset mid-APPLY
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_din",  32'(dut_in), 32'h0);
    chk("async_rst_sig",  32'(signature), 32'h0);
    chk("async_rst_idx",  32'(pat_idx), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      dut_out = 10'($urandom);
      start   = ($urandom_range(0, 99) < 6);
      abort   = ($urandom_range(0, 299) == 0);
      golden  = $urandom_range(0, 1) ? misr_f(m_sig, dut_out) : 10'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
